// File: rtl/hack_kbd_fifo4_pkg.sv
// Shared widths, constants and request/state types for the Hack keyboard scan-code FIFO.
package hack_kbd_fifo4_pkg;

  localparam int HACK_WORD_W    = 16;
  localparam int KBD_FIFO_DEPTH = 4;
  localparam int KBD_PTR_W      = 2;
  localparam int KBD_CNT_W      = 3;

  localparam logic [HACK_WORD_W-1:0] KBD_NO_KEY = 16'h0000;

  typedef logic [HACK_WORD_W-1:0] hack_word_t;
  typedef logic [KBD_PTR_W-1:0]   kbd_ptr_t;
  typedef logic [KBD_CNT_W-1:0]   kbd_cnt_t;

  // One cycle's worth of requests from the capture side and the register side.
  typedef struct packed {
    logic       clear;
    logic       wr_en;
    hack_word_t wr_data;
    logic       rd_en;
  } kbd_req_t;

  // Accepted operations after the full/empty qualification.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } kbd_op_t;

  function automatic kbd_op_t kbd_qualify(input kbd_req_t req, input logic full,
                                          input logic empty);
    kbd_op_t op;
    op.push = req.wr_en && (!full || req.rd_en);
    op.pop  = req.rd_en && !empty;
    op.drop = req.wr_en && full && !req.rd_en;
    return op;
  endfunction

  // Occupancy moves only when exactly one of push/pop happens.
  function automatic kbd_cnt_t kbd_next_count(input kbd_cnt_t cnt, input kbd_op_t op);
    kbd_cnt_t nxt;
    nxt = cnt;
    if (op.push && !op.pop)      nxt = cnt + 3'd1;
    else if (op.pop && !op.push) nxt = cnt - 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/hack_mux4_way16.sv
// Hack 4-way 16-bit multiplexer: sel 00->a, 01->b, 10->c, 11->d.
module hack_mux4_way16
  import hack_kbd_fifo4_pkg::*;
(
  input  logic [HACK_WORD_W-1:0] a,
  input  logic [HACK_WORD_W-1:0] b,
  input  logic [HACK_WORD_W-1:0] c,
  input  logic [HACK_WORD_W-1:0] d,
  input  logic [1:0]             sel,
  output logic [HACK_WORD_W-1:0] out
);

  logic [HACK_WORD_W-1:0] ab, cd;

  // Two-level tree, matching the classic Mux16 decomposition.
  assign ab  = sel[0] ? b : a;
  assign cd  = sel[0] ? d : c;
  assign out = sel[1] ? cd : ab;

endmodule

// File: rtl/hack_kbd_fifo4.sv
// 4-entry show-ahead FIFO between keyboard capture and the KBD register; reads 0 when empty.
module hack_kbd_fifo4
  import hack_kbd_fifo4_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [HACK_WORD_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [HACK_WORD_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [KBD_CNT_W-1:0]   count,
  output logic                   overflow
);

  localparam int WIDTH = HACK_WORD_W;
  localparam int DEPTH = KBD_FIFO_DEPTH;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  kbd_ptr_t                    wr_ptr, rd_ptr;
  kbd_cnt_t                    cnt;
  logic                        ovf;
  kbd_req_t                    req;
  kbd_op_t                     op;
  hack_word_t                  head;

  assign req   = '{clear: clear, wr_en: wr_en, wr_data: wr_data, rd_en: rd_en};
  assign empty = (cnt == '0);
  assign full  = (cnt == KBD_CNT_W'(DEPTH));
  assign op    = kbd_qualify(req, full, empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (req.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (op.push) wr_ptr <= wr_ptr + 2'd1;
      if (op.pop)  rd_ptr <= rd_ptr + 2'd1;
      cnt <= kbd_next_count(cnt, op);
      if (op.drop) ovf <= 1'b1;
    end
  end

  // Storage is flushed only by reset; clear just rewinds the pointers.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[i] <= '0;
        else if (!req.clear && op.push && (wr_ptr == kbd_ptr_t'(i)))
          mem[i] <= req.wr_data;
      end
    end
  endgenerate

  hack_mux4_way16 u_rd_mux (
    .a   (mem[0]),
    .b   (mem[1]),
    .c   (mem[2]),
    .d   (mem[3]),
    .sel (rd_ptr),
    .out (head)
  );

  assign rd_data  = empty ? KBD_NO_KEY : head;
  assign count    = cnt;
  assign overflow = ovf;

endmodule

// File: tb/tb_hack_kbd_fifo4.sv
// Self-checking bench: constant vector table plus a queue scoreboard of expected pop data.
module tb_hack_kbd_fifo4;

  logic        clk = 1'b0;
  logic        rst_n, clear, wr_en, rd_en;
  logic [15:0] wr_data, rd_data;
  logic        empty, full, overflow;
  logic [2:0]  count;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] sb[$];
  logic        ovf_m;

  typedef struct {
    string       name;
    logic        clr;
    logic        we;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  e_cnt;
    logic [15:0] e_rd;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hack_kbd_fifo4 dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, ".count"},    16'(count),    16'(sb.size()));
    chk({name, ".empty"},    16'(empty),    16'(sb.size() == 0));
    chk({name, ".full"},     16'(full),     16'(sb.size() == 4));
    chk({name, ".overflow"}, 16'(overflow), 16'(ovf_m));
    chk({name, ".rd_data"},  rd_data,       (sb.size() != 0) ? sb[0] : 16'h0000);
  endtask

  // Drive one cycle; called just after a posedge, returns #1 after the next posedge.
  task automatic step(input string name, input logic clr, input logic we,
                      input logic [15:0] wd, input logic re);
    logic push_ok, pop_ok, drop;
    clear = clr; wr_en = we; wr_data = wd; rd_en = re;
    push_ok = !clr && we && ((sb.size() < 4) || re);
    pop_ok  = !clr && re && (sb.size() != 0);
    drop    = !clr && we && (sb.size() == 4) && !re;
    @(negedge clk);
    if (pop_ok) chk({name, ".popped"}, rd_data, sb[0]);
    @(posedge clk);
    #1;
    if (clr) begin
      sb.delete();
      ovf_m = 1'b0;
    end else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(wd);
      if (drop)    ovf_m = 1'b1;
    end
    clear = 0; wr_en = 0; rd_en = 0;
    chk_model(name);
  endtask

  function automatic vec_t mk(input string n, input logic c, input logic w,
                              input logic [15:0] d, input logic r, input logic [2:0] ec,
                              input logic [15:0] er, input logic eo);
    vec_t v;
    v.name = n; v.clr = c; v.we = w; v.wd = d; v.re = r;
    v.e_cnt = ec; v.e_rd = er; v.e_ovf = eo;
    return v;
  endfunction

  initial begin
    rst_n = 0; clear = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    ovf_m = 0;

    // fill / drain in order
    tbl.push_back(mk("fill41", 0, 1, 16'h0041, 0, 3'd1, 16'h0041, 0));
    tbl.push_back(mk("fill42", 0, 1, 16'h0042, 0, 3'd2, 16'h0041, 0));
    tbl.push_back(mk("fill43", 0, 1, 16'h0043, 0, 3'd3, 16'h0041, 0));
    tbl.push_back(mk("fill44", 0, 1, 16'h0044, 0, 3'd4, 16'h0041, 0));
    tbl.push_back(mk("drain1", 0, 0, 16'h0000, 1, 3'd3, 16'h0042, 0));
    tbl.push_back(mk("drain2", 0, 0, 16'h0000, 1, 3'd2, 16'h0043, 0));
    tbl.push_back(mk("drain3", 0, 0, 16'h0000, 1, 3'd1, 16'h0044, 0));
    tbl.push_back(mk("drain4", 0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    // overflow then clear
    tbl.push_back(mk("refill41", 0, 1, 16'h0041, 0, 3'd1, 16'h0041, 0));
    tbl.push_back(mk("refill42", 0, 1, 16'h0042, 0, 3'd2, 16'h0041, 0));
    tbl.push_back(mk("refill43", 0, 1, 16'h0043, 0, 3'd3, 16'h0041, 0));
    tbl.push_back(mk("refill44", 0, 1, 16'h0044, 0, 3'd4, 16'h0041, 0));
    tbl.push_back(mk("ovf80",    0, 1, 16'h0080, 0, 3'd4, 16'h0041, 1));
    tbl.push_back(mk("ovfhold",  0, 0, 16'h0000, 0, 3'd4, 16'h0041, 1));
    tbl.push_back(mk("clear",    1, 0, 16'h0000, 0, 3'd0, 16'h0000, 0));
    // simultaneous push+pop when full, then when empty
    tbl.push_back(mk("f01", 0, 1, 16'h0001, 0, 3'd1, 16'h0001, 0));
    tbl.push_back(mk("f02", 0, 1, 16'h0002, 0, 3'd2, 16'h0001, 0));
    tbl.push_back(mk("f03", 0, 1, 16'h0003, 0, 3'd3, 16'h0001, 0));
    tbl.push_back(mk("f04", 0, 1, 16'h0004, 0, 3'd4, 16'h0001, 0));
    tbl.push_back(mk("fullpp85", 0, 1, 16'h0085, 1, 3'd4, 16'h0002, 0));
    tbl.push_back(mk("p03", 0, 0, 16'h0000, 1, 3'd3, 16'h0003, 0));
    tbl.push_back(mk("p04", 0, 0, 16'h0000, 1, 3'd2, 16'h0004, 0));
    tbl.push_back(mk("p85", 0, 0, 16'h0000, 1, 3'd1, 16'h0085, 0));
    tbl.push_back(mk("pend", 0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    tbl.push_back(mk("emptypp30", 0, 1, 16'h0030, 1, 3'd1, 16'h0030, 0));
    tbl.push_back(mk("p30", 0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    // pointer wrap: rewind, advance both pointers to 3, then write mem[3], mem[0]
    tbl.push_back(mk("wclr", 1, 0, 16'h0000, 0, 3'd0, 16'h0000, 0));
    tbl.push_back(mk("wa1", 0, 1, 16'h00A1, 0, 3'd1, 16'h00A1, 0));
    tbl.push_back(mk("wa2", 0, 1, 16'h00A2, 0, 3'd2, 16'h00A1, 0));
    tbl.push_back(mk("wa3", 0, 1, 16'h00A3, 0, 3'd3, 16'h00A1, 0));
    tbl.push_back(mk("wp1", 0, 0, 16'h0000, 1, 3'd2, 16'h00A2, 0));
    tbl.push_back(mk("wp2", 0, 0, 16'h0000, 1, 3'd1, 16'h00A3, 0));
    tbl.push_back(mk("wp3", 0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    tbl.push_back(mk("w1234", 0, 1, 16'h1234, 0, 3'd1, 16'h1234, 0));
    tbl.push_back(mk("w9876", 0, 1, 16'h9876, 0, 3'd2, 16'h1234, 0));
    tbl.push_back(mk("wpa",   0, 0, 16'h0000, 1, 3'd1, 16'h9876, 0));
    tbl.push_back(mk("wpb",   0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    // pop on empty, clear beats push
    tbl.push_back(mk("popempty", 0, 0, 16'h0000, 1, 3'd0, 16'h0000, 0));
    tbl.push_back(mk("clrpush",  1, 1, 16'h00FF, 0, 3'd0, 16'h0000, 0));
    tbl.push_back(mk("afterclr", 0, 0, 16'h0000, 0, 3'd0, 16'h0000, 0));

    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk_model("inreset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_model("idle");

    // asynchronous reset mid-fill
    step("pre11", 0, 1, 16'h0011, 0);
    step("pre22", 0, 1, 16'h0022, 0);
    #2 rst_n = 0;
    #1;
    sb.delete();
    ovf_m = 0;
    chk_model("asyncrst");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_model("postrst");

    foreach (tbl[i]) begin
      step(tbl[i].name, tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk({tbl[i].name, ".tcount"}, 16'(count),    16'(tbl[i].e_cnt));
      chk({tbl[i].name, ".trd"},    rd_data,       tbl[i].e_rd);
      chk({tbl[i].name, ".tovf"},   16'(overflow), 16'(tbl[i].e_ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
